fetch_packet_sender: RTL and testbench

Front-end producer that feeds the instruction queue. It holds the fetch PC, issues one 16-byte line request at a time to the I-cache, and rotates the returned line so that slot 0 holds the instruction at the fetch PC. It trims the packet at line end, at a predicted-taken branch, or at a fetch exception, then delivers it as a single-cycle packet. It obeys the queue's stop-fetch back-pressure and restarts from a redirect PC on flush or exception.

---
 rtl/fetch_packet_sender.sv | 198 +++++++++++++++++++
 tb/tb_fetch_packet_sender.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_packet_sender.sv
// fetch_packet_sender: owns the fetch PC, issues one I-cache line request at a
// time and turns the returned line into a rotated, trimmed fetch packet.
// Define DELAY_SLOT_EN to keep a taken branch's delay slot in its packet.
module fetch_packet_sender #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          EXC_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid_i,
    input  logic [31:0]      redirect_pc_i,
    input  logic             IQ_stopFetch_i,
    output logic             ic_req_o,
    output logic [31:0]      ic_addr_o,
    input  logic             ic_ack_i,
    input  logic             ic_rvalid_i,
    input  logic [127:0]     ic_rdata_i,
    input  logic             ic_hasExc_i,
    input  logic [EXC_W-1:0] ic_ExcCode_i,
    input  logic             ic_isRefill_i,
    input  logic [3:0]       bp_predTake_i,
    input  logic [127:0]     bp_predDest_i,
    output logic             IF_valid_o,
    output logic [3:0]       IF_instEnable_o,
    output logic [2:0]       IF_instNum_o,
    output logic [31:0]      IF_instBasePC_o,
    output logic [127:0]     IF_inst_p_o,
    output logic [3:0]       IF_predTake_p_o,
    output logic [127:0]     IF_predDest_p_o,
    output logic             IF_hasException_o,
    output logic [EXC_W-1:0] IF_ExcCode_o,
    output logic             IF_isRefill_o
);
    typedef enum logic [1:0] { S_REQ, S_WAIT, S_HOLD, S_EXCSTOP } state_t;

    state_t           state;
    logic [31:0]      pc;
    logic             drop;
`ifdef DELAY_SLOT_EN
    logic             pend_valid;
    logic [31:0]      pend_target;
    logic             set_pend;
`endif

    logic [3:0][31:0] line_w, dest_w;
    logic [3:0][31:0] rot_inst, rot_dest, pkt_inst, pkt_dest;
    logic [3:0]       rot_take, pkt_take, en;
    logic [1:0]       off, k;
    logic [2:0]       base_cnt, cnt;
    logic             found;
    logic [31:0]      seq_pc, nxt_pc;

    assign line_w    = ic_rdata_i;
    assign dest_w    = bp_predDest_i;
    assign ic_req_o  = (state == S_REQ) && !drop;
    assign ic_addr_o = pc;

    // Rotate the line so slot 0 holds the word at pc; slots past line end are 0.
    always_comb begin
        off      = pc[3:2];
        base_cnt = 3'd4 - {1'b0, off};
        rot_inst = '0;
        rot_dest = '0;
        rot_take = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < base_cnt) begin
                rot_inst[i] = line_w[off + 2'(i)];
                rot_dest[i] = dest_w[off + 2'(i)];
                rot_take[i] = bp_predTake_i[off + 2'(i)];
            end
        end
    end

    // Choose packet length and next pc from exception, taken branch or line end.
    always_comb begin
        found = 1'b0;
        k     = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_take[i]) begin
                found = 1'b1;
                k     = 2'(i);
            end
        end
        seq_pc = {pc[31:4] + 28'd1, 4'b0000};
        cnt    = base_cnt;
        nxt_pc = seq_pc;
`ifdef DELAY_SLOT_EN
        set_pend = 1'b0;
        if (ic_hasExc_i) begin
            cnt = 3'd1;
        end else if (pend_valid) begin
            cnt    = 3'd1;
            nxt_pc = pend_target;
        end else if (found) begin
            if ({1'b0, k} + 3'd1 < base_cnt) begin
                cnt    = {1'b0, k} + 3'd2;
                nxt_pc = rot_dest[k];
            end else begin
                cnt      = {1'b0, k} + 3'd1;
                set_pend = 1'b1;
            end
        end
`else
        if (ic_hasExc_i) begin
            cnt = 3'd1;
        end else if (found) begin
            cnt    = {1'b0, k} + 3'd1;
            nxt_pc = rot_dest[k];
        end
`endif
        en       = 4'((5'd1 << cnt) - 5'd1);
        pkt_inst = '0;
        pkt_dest = '0;
        for (int i = 0; i < 4; i++) begin
            pkt_inst[i] = en[i] ? rot_inst[i] : 32'd0;
            pkt_dest[i] = en[i] ? rot_dest[i] : 32'd0;
        end
        pkt_take = rot_take & en;
    end

    // Fetch FSM; the IF_* registers double as the HOLD buffer while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_REQ;
            pc                <= RESET_PC;
            drop              <= 1'b0;
            IF_valid_o        <= 1'b0;
            IF_instEnable_o   <= '0;
            IF_instNum_o      <= '0;
            IF_instBasePC_o   <= '0;
            IF_inst_p_o       <= '0;
            IF_predTake_p_o   <= '0;
            IF_predDest_p_o   <= '0;
            IF_hasException_o <= 1'b0;
            IF_ExcCode_o      <= '0;
            IF_isRefill_o     <= 1'b0;
`ifdef DELAY_SLOT_EN
            pend_valid        <= 1'b0;
            pend_target       <= '0;
`endif
        end else begin
            IF_valid_o <= 1'b0;
            if (redirect_valid_i) begin
                pc    <= redirect_pc_i;
                state <= S_REQ;
                drop  <= ((state == S_WAIT) && !ic_rvalid_i) ||
                         (ic_req_o && ic_ack_i) ||
                         (drop && !ic_rvalid_i);
`ifdef DELAY_SLOT_EN
                pend_valid <= 1'b0;
`endif
            end else begin
                if (drop && ic_rvalid_i) drop <= 1'b0;
                unique case (state)
                    S_REQ: begin
                        if (ic_req_o && ic_ack_i) state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (ic_rvalid_i) begin
                            pc                <= nxt_pc;
                            IF_instEnable_o   <= en;
                            IF_instNum_o      <= cnt;
                            IF_instBasePC_o   <= pc;
                            IF_inst_p_o       <= pkt_inst;
                            IF_predTake_p_o   <= pkt_take;
                            IF_predDest_p_o   <= pkt_dest;
                            IF_hasException_o <= ic_hasExc_i;
                            IF_ExcCode_o      <= ic_ExcCode_i;
                            IF_isRefill_o     <= ic_isRefill_i;
`ifdef DELAY_SLOT_EN
                            if (!ic_hasExc_i) begin
                                pend_valid <= set_pend;
                                if (set_pend) pend_target <= rot_dest[k];
                            end
`endif
                            if (!IQ_stopFetch_i) begin
                                IF_valid_o <= 1'b1;
                                state      <= ic_hasExc_i ? S_EXCSTOP : S_REQ;
                            end else begin
                                state <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!IQ_stopFetch_i) begin
                            IF_valid_o <= 1'b1;
                            state      <= IF_hasException_o ? S_EXCSTOP : S_REQ;
                        end
                    end
                    S_EXCSTOP: begin
                        state <= S_EXCSTOP;
                    end
                    default: state <= S_REQ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_packet_sender.sv
// tb_fetch_packet_sender: directed table, drop sequence and random packets
// checked against a slot-list model of fetch packet formation.
module tb_fetch_packet_sender;
`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         iq_stop;
    logic         ic_req;
    logic [31:0]  ic_addr;
    logic         ic_ack;
    logic         ic_rvalid;
    logic [127:0] ic_rdata;
    logic         ic_exc;
    logic [4:0]   ic_code;
    logic         ic_refill;
    logic [3:0]   bp_take;
    logic [127:0] bp_dest;
    logic         if_valid;
    logic [3:0]   if_en;
    logic [2:0]   if_num;
    logic [31:0]  if_base;
    logic [127:0] if_inst;
    logic [3:0]   if_take;
    logic [127:0] if_dest;
    logic         if_exc;
    logic [4:0]   if_code;
    logic         if_refill;

    always #5 clk = ~clk;

    fetch_packet_sender #(.RESET_PC(32'hBFC0_0000), .EXC_W(5)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .IQ_stopFetch_i(iq_stop),
        .ic_req_o(ic_req), .ic_addr_o(ic_addr), .ic_ack_i(ic_ack),
        .ic_rvalid_i(ic_rvalid), .ic_rdata_i(ic_rdata),
        .ic_hasExc_i(ic_exc), .ic_ExcCode_i(ic_code), .ic_isRefill_i(ic_refill),
        .bp_predTake_i(bp_take), .bp_predDest_i(bp_dest),
        .IF_valid_o(if_valid), .IF_instEnable_o(if_en), .IF_instNum_o(if_num),
        .IF_instBasePC_o(if_base), .IF_inst_p_o(if_inst),
        .IF_predTake_p_o(if_take), .IF_predDest_p_o(if_dest),
        .IF_hasException_o(if_exc), .IF_ExcCode_o(if_code), .IF_isRefill_o(if_refill)
    );

    typedef struct {
        logic [3:0]   en;
        logic [2:0]   num;
        logic [31:0]  base;
        logic [127:0] inst;
        logic [3:0]   take;
        logic [127:0] dest;
        logic         exc;
        logic [4:0]   code;
        logic         refill;
    } pkt_t;

    typedef struct {
        bit           redir;
        logic [31:0]  start;
        logic [127:0] line;
        logic [3:0]   pt;
        logic [127:0] pd;
        logic         exc;
        logic [4:0]   code;
        logic         refill;
        int           stop;
        logic [3:0]   en;
        logic [2:0]   num;
        logic [127:0] inst;
        logic [31:0]  next;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_tgt;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: the packet is the list of line words from pc onward, cut after
    // the first taken branch (or its delay slot), or to one word on exception.
    task automatic predict(input logic [127:0] line, input logic [3:0] pt,
                           input logic [127:0] pd, input logic exc,
                           input logic [4:0] code, input logic refill,
                           output pkt_t p);
        int          first, avail, cnt;
        logic [31:0] nxt, tgt;
        bit          np;
        first = int'(m_pc[3:2]);
        avail = 4 - first;
        cnt   = avail;
        nxt   = (m_pc & 32'hFFFF_FFF0) + 32'h10;
        np    = 1'b0;
        tgt   = '0;
        if (exc) begin
            cnt = 1;
        end else if (DS && m_pend) begin
            cnt = 1;
            nxt = m_tgt;
        end else begin
            for (int j = 0; j < avail; j++) begin
                if (pt[first + j]) begin
                    if (!DS) begin
                        cnt = j + 1;
                        nxt = pd[32*(first+j) +: 32];
                    end else if (j + 1 < avail) begin
                        cnt = j + 2;
                        nxt = pd[32*(first+j) +: 32];
                    end else begin
                        cnt = j + 1;
                        np  = 1'b1;
                        tgt = pd[32*(first+j) +: 32];
                    end
                    break;
                end
            end
        end
        p.inst = '0;
        p.dest = '0;
        p.take = '0;
        for (int j = 0; j < cnt; j++) begin
            p.inst[32*j +: 32] = line[32*(first+j) +: 32];
            p.dest[32*j +: 32] = pd[32*(first+j) +: 32];
            p.take[j]          = pt[first + j];
        end
        p.en     = 4'((1 << cnt) - 1);
        p.num    = 3'(cnt);
        p.base   = m_pc;
        p.exc    = exc;
        p.code   = code;
        p.refill = refill;
        m_pc = nxt;
        if (!exc) begin
            m_pend = np;
            m_tgt  = tgt;
        end
    endtask

    task automatic cmp_pkt(input pkt_t g, input pkt_t e);
        check("enable", g.en, e.en);
        check("num", g.num, e.num);
        check("base", g.base, e.base);
        check("inst", g.inst, e.inst);
        check("take", g.take, e.take);
        check("dest", g.dest, e.dest);
        check("exc", g.exc, e.exc);
        check("code", g.code, e.code);
        check("refill", g.refill, e.refill);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ic_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("req_timeout", 0, 1);
    endtask

    task automatic redirect(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("redir_valid_low", if_valid, 0);
        m_pc   = a;
        m_pend = 1'b0;
    endtask

    task automatic fetch(input logic [127:0] line, input logic [3:0] pt,
                         input logic [127:0] pd, input logic exc,
                         input logic [4:0] code, input logic refill,
                         input int lat, input int stop,
                         output pkt_t got, output bit ok);
        wait_req(ok);
        if (!ok) return;
        check("ic_addr", ic_addr, m_pc);
        ic_ack = 1'b1;
        @(negedge clk);
        ic_ack = 1'b0;
        check("one_outstanding", ic_req, 0);
        repeat (lat) @(negedge clk);
        ic_rvalid = 1'b1;
        ic_rdata  = line;
        bp_take   = pt;
        bp_dest   = pd;
        ic_exc    = exc;
        ic_code   = code;
        ic_refill = refill;
        iq_stop   = (stop > 0);
        @(negedge clk);
        ic_rvalid = 1'b0;
        ic_rdata  = {$urandom, $urandom, $urandom, $urandom};
        bp_take   = 4'($urandom);
        bp_dest   = {$urandom, $urandom, $urandom, $urandom};
        ic_exc    = 1'b0;
        ic_code   = '0;
        ic_refill = 1'b0;
        for (int s = 0; s < stop; s++) begin
            check("hold_quiet", if_valid, 0);
            @(negedge clk);
        end
        iq_stop = 1'b0;
        if (stop > 0) @(negedge clk);
        check("pkt_valid", if_valid, 1);
        got.en     = if_en;
        got.num    = if_num;
        got.base   = if_base;
        got.inst   = if_inst;
        got.take   = if_take;
        got.dest   = if_dest;
        got.exc    = if_exc;
        got.code   = if_code;
        got.refill = if_refill;
        @(negedge clk);
        check("pkt_single", if_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vt[5];
        pkt_t         g, e;
        bit           ok;
        logic [127:0] line, pd;
        logic [3:0]   pt;
        logic         exc, refill;
        logic [4:0]   code;

        vt[0] = '{1'b0, 32'hBFC0_0000, 128'h11110003_11110002_11110001_11110000,
                  4'b0000, 128'h0, 1'b0, 5'h0, 1'b0, 0,
                  4'b1111, 3'd4, 128'h11110003_11110002_11110001_11110000, 32'hBFC0_0010};
        vt[1] = '{1'b1, 32'h8000_0008, 128'h22220003_22220002_22220001_22220000,
                  4'b0000, 128'h0, 1'b0, 5'h0, 1'b0, 0,
                  4'b0011, 3'd2, 128'h00000000_00000000_22220003_22220002, 32'h8000_0010};
        vt[2] = '{1'b1, 32'h8000_0000, 128'h33330003_33330002_33330001_33330000,
                  4'b0010, 128'h00000000_00000000_80001000_00000000, 1'b0, 5'h0, 1'b0, 0,
                  4'b0011, 3'd2, 128'h00000000_00000000_33330001_33330000, 32'h8000_1000};
        if (DS) begin
            vt[2].en   = 4'b0111;
            vt[2].num  = 3'd3;
            vt[2].inst = 128'h00000000_33330002_33330001_33330000;
        end
        vt[3] = '{1'b0, 32'h8000_1000, 128'h44440003_44440002_44440001_44440000,
                  4'b0000, 128'h0, 1'b0, 5'h0, 1'b0, 5,
                  4'b1111, 3'd4, 128'h44440003_44440002_44440001_44440000, 32'h8000_1010};
        vt[4] = '{1'b1, 32'h9000_0004, 128'h55550003_55550002_55550001_55550000,
                  4'b0000, 128'h0, 1'b1, 5'h02, 1'b1, 0,
                  4'b0001, 3'd1, 128'h00000000_00000000_00000000_55550001, 32'h0};

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        iq_stop        = 1'b0;
        ic_ack         = 1'b0;
        ic_rvalid      = 1'b0;
        ic_rdata       = '0;
        ic_exc         = 1'b0;
        ic_code        = '0;
        ic_refill      = 1'b0;
        bp_take        = '0;
        bp_dest        = '0;
        m_pc           = 32'hBFC0_0000;
        m_pend         = 1'b0;
        m_tgt          = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", if_valid, 0);
        check("rst_en", if_en, 0);
        check("rst_num", if_num, 0);
        check("rst_inst", if_inst, 0);
        check("rst_addr", ic_addr, 32'hBFC0_0000);
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            if (vt[t].redir) redirect(vt[t].start);
            fetch(vt[t].line, vt[t].pt, vt[t].pd, vt[t].exc, vt[t].code,
                  vt[t].refill, 1, vt[t].stop, g, ok);
            predict(vt[t].line, vt[t].pt, vt[t].pd, vt[t].exc, vt[t].code,
                    vt[t].refill, e);
            if (ok) begin
                check("t_enable", g.en, vt[t].en);
                check("t_num", g.num, vt[t].num);
                check("t_base", g.base, vt[t].start);
                check("t_inst", g.inst, vt[t].inst);
                check("t_exc", g.exc, vt[t].exc);
                check("t_code", g.code, vt[t].code);
                check("t_refill", g.refill, vt[t].refill);
                cmp_pkt(g, e);
                if (vt[t].exc) begin
                    for (int c = 0; c < 4; c++) begin
                        check("excstop_noreq", ic_req, 0);
                        @(negedge clk);
                    end
                end else begin
                    wait_req(ok);
                    if (ok) check("t_next_addr", ic_addr, vt[t].next);
                end
            end
        end

        redirect(32'h8000_0100);
        wait_req(ok);
        check("drop_first_addr", ic_addr, 32'h8000_0100);
        ic_ack = 1'b1;
        @(negedge clk);
        ic_ack = 1'b0;
        redirect(32'h8000_0200);
        check("drop_req_gated", ic_req, 0);
        @(negedge clk);
        check("drop_req_gated2", ic_req, 0);
        ic_rvalid = 1'b1;
        ic_rdata  = 128'h66660003_66660002_66660001_66660000;
        @(negedge clk);
        ic_rvalid = 1'b0;
        check("drop_no_valid", if_valid, 0);
        check("drop_req_back", ic_req, 1);
        check("drop_new_addr", ic_addr, 32'h8000_0200);
        @(negedge clk);
        check("drop_no_valid2", if_valid, 0);
        line = 128'h77770003_77770002_77770001_77770000;
        fetch(line, 4'b0000, 128'h0, 1'b0, 5'h0, 1'b0, 0, 0, g, ok);
        predict(line, 4'b0000, 128'h0, 1'b0, 5'h0, 1'b0, e);
        if (ok) cmp_pkt(g, e);

        for (int r = 0; r < 60; r++) begin
            if ($urandom_range(0, 4) == 0)
                redirect({4'h8, 26'($urandom), 2'b00});
            line   = {$urandom, $urandom, $urandom, $urandom};
            pd     = {$urandom, $urandom, $urandom, $urandom} & 128'hFFFFFFFC_FFFFFFFC_FFFFFFFC_FFFFFFFC;
            pt     = 4'($urandom) & 4'($urandom);
            exc    = ($urandom_range(0, 7) == 0);
            code   = exc ? 5'($urandom) : 5'h0;
            refill = exc ? 1'($urandom) : 1'b0;
            fetch(line, pt, pd, exc, code, refill, $urandom_range(0, 2),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0, g, ok);
            predict(line, pt, pd, exc, code, refill, e);
            if (ok) cmp_pkt(g, e);
            if (exc) begin
                @(negedge clk);
                check("rnd_excstop_noreq", ic_req, 0);
                redirect({4'h8, 26'($urandom), 2'b00});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
